// File: rtl/csa_serial_accum_10_8_pkg.sv
// Shared definitions for the serial carry-save accumulator.
//   - Default operand count, operand width and result width.
//   - FSM state encoding, shared so that other blocks (e.g. the combinational
//     tree variant) use the same encodings.
package csa_serial_accum_10_8_pkg;

    localparam int N_OPS_DEF     = 10;
    localparam int WIDTH_DEF     = 8;
    // 2^SUM_WIDTH must exceed N_OPS*(2^WIDTH-1); 10*255 = 2550 < 4096.
    localparam int SUM_WIDTH_DEF = 12;
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/csa_3_2_row.sv
// One row of 3:2 carry-save compressors, purely combinational.
// Ports:
//   x, y, w : three W-bit addends
//   s       : bitwise sum (x ^ y ^ w)
//   c       : bitwise majority, already shifted left by one and truncated to W
// x + y + w == s + c (mod 2^W).
module csa_3_2_row #(
    parameter int W = 12
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] w,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    logic [W-1:0] maj;

    assign s   = x ^ y ^ w;
    assign maj = (x & y) | (x & w) | (y & w);
    assign c   = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_serial_accum_10_8.sv
// Serial carry-save accumulator: sums N_OPS unsigned WIDTH-bit operands, one
// per input handshake, keeping the running total in redundant sum/carry form.
// After the last operand a single carry-propagate add resolves the pair into z,
// which is then offered on an output handshake.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   a, in_valid/in_ready: operand input handshake (accepted only in ACCUM)
//   z, out_valid/out_ready : result output handshake (valid only in DONE)
//   op_count            : operands accepted so far in the current group
module csa_serial_accum_10_8
    import csa_serial_accum_10_8_pkg::*;
#(
    parameter int N_OPS     = N_OPS_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int SUM_WIDTH = SUM_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     a,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SUM_WIDTH-1:0] z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     op_count
);

    localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(N_OPS - 1);

    state_t                 state, state_nxt;
    logic [SUM_WIDTH-1:0]   s_reg, c_reg;
    logic [SUM_WIDTH-1:0]   s_nxt, c_nxt;
    logic [SUM_WIDTH-1:0]   a_ext;
    logic                   accept, xfer, last_op;

    assign a_ext   = SUM_WIDTH'(a);
    assign accept  = in_valid & in_ready;
    assign xfer    = out_valid & out_ready;
    assign last_op = (op_count == LAST_OP);

    csa_3_2_row #(.W(SUM_WIDTH)) u_row (
        .x (s_reg),
        .y (c_reg),
        .w (a_ext),
        .s (s_nxt),
        .c (c_nxt)
    );

    // Handshake outputs are pure decodes of the state, so in_ready only
    // returns the cycle after a transfer (no bypass from out_ready).
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (accept && last_op) state_nxt = ST_RESOLVE;
            end
            ST_RESOLVE: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (xfer) state_nxt = ST_ACCUM;
            end
            default: state_nxt = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_ACCUM;
            s_reg    <= '0;
            c_reg    <= '0;
            op_count <= '0;
            z        <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        s_reg    <= s_nxt;
                        c_reg    <= c_nxt;
                        op_count <= last_op ? '0 : op_count + 1'b1;
                    end
                end
                ST_RESOLVE: begin
                    // Only carry-propagate add in the block; width rule
                    // guarantees no overflow.
                    z <= s_reg + c_reg;
                end
                ST_DONE: begin
                    // Clear the pair so the next group starts from zero.
                    if (xfer) begin
                        s_reg <= '0;
                        c_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_serial_accum_10_8.sv
// Self-checking bench for csa_serial_accum_10_8: directed groups from the
// block's test plan plus randomized groups, all checked against a plain
// integer-sum reference and cycle-accurate handshake timing expectations.
module tb_csa_serial_accum_10_8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  a;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] z;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  op_count;

    int n_cmp = 0;
    int n_err = 0;

    csa_serial_accum_10_8 dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge; all driving and sampling happens 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_in_ready"},  int'(in_ready),  1);
        chk({tag, "_op_count"},  int'(op_count),  0);
        chk({tag, "_z"},         int'(z),         0);
    endtask

    // Present one operand for exactly one accepting edge, then idle gap cycles.
    task automatic feed(input int v, input int gap);
        in_valid = 1'b1;
        a        = 8'(v);
        step();
        in_valid = 1'b0;
        a        = 8'($urandom);
        for (int g = 0; g < gap; g++) step();
    endtask

    // Full group: ten operands, then resolve/done timing and the transfer.
    // gap < 0 picks a random idle gap (0..2) before each following operand.
    task automatic run_group(input int ops[10], input int gap, input int stall);
        int exp_sum = 0;
        int g;
        for (int i = 0; i < 10; i++) begin
            chk("op_count", int'(op_count), i);
            chk("in_ready", int'(in_ready), 1);
            chk("out_valid_accum", int'(out_valid), 0);
            exp_sum += ops[i];
            g = (i == 9) ? 0 : ((gap < 0) ? int'($urandom_range(0, 2)) : gap);
            feed(ops[i], g);
        end
        // RESOLVE: one cycle after the last accept, nothing visible yet.
        chk("rs_in_ready",  int'(in_ready),  0);
        chk("rs_out_valid", int'(out_valid), 0);
        chk("rs_op_count",  int'(op_count),  0);
        in_valid  = 1'b1;          // must be ignored
        a         = 8'hA5;
        out_ready = (stall == 0);
        step();
        chk("z", int'(z), exp_sum);
        chk("done_out_valid", int'(out_valid), 1);
        chk("done_in_ready",  int'(in_ready),  0);
        for (int s = 0; s < stall; s++) begin
            in_valid = s[0];
            a        = 8'($urandom);
            step();
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_z",         int'(z),         exp_sum);
            chk("stall_in_ready",  int'(in_ready),  0);
            chk("stall_op_count",  int'(op_count),  0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_out_valid", int'(out_valid), 0);
        chk("post_in_ready",  int'(in_ready),  1);
        chk("post_op_count",  int'(op_count),  0);
    endtask

    initial begin
        int grp[10];
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        step();
        step();
        chk_reset_state("reset");
        reset = 1'b0;

        // 1..10, back-to-back, consumer always ready -> 55
        grp = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        run_group(grp, 0, 0);

        // All-ones maximum -> 2550, no truncation
        grp = '{255, 255, 255, 255, 255, 255, 255, 255, 255, 255};
        run_group(grp, 0, 0);

        // One idle cycle between beats -> 75
        grp = '{11, 2, 13, 4, 5, 6, 7, 8, 9, 10};
        run_group(grp, 1, 0);

        // Zeros with a 5-cycle stall, then ones to prove no residue
        grp = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_group(grp, 0, 5);
        grp = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        run_group(grp, 0, 0);

        // Reset mid-group discards the partial sum
        for (int i = 0; i < 4; i++) feed(50, 0);
        chk("mid_op_count", int'(op_count), 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_state("mid_reset");
        grp = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
        run_group(grp, 0, 0);

        // Reset while holding a result in DONE
        for (int i = 0; i < 10; i++) feed(int'($urandom_range(0, 255)), 0);
        step();
        chk("dr_out_valid", int'(out_valid), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_state("done_reset");

        // Randomized groups, random gaps and stalls
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 10; i++) grp[i] = int'($urandom_range(0, 255));
            if (r == 0) grp[0] = 255;
            run_group(grp, -1, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
